// File: rtl/descriptor_extract_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// descriptor_extract_pkg: shared types, header indices and descriptor layout
// Revision: 1.0
// ----------------------------------------------------------------------------
package descriptor_extract_pkg;

  typedef enum logic [1:0] {
    CLS_TS = 2'b00,
    CLS_RC = 2'b01,
    CLS_BE = 2'b10
  } pkt_class_t;

  typedef enum logic [0:0] {
    P_IDLE  = 1'b0,
    P_FRAME = 1'b1
  } parse_state_t;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_BUF = 2'd1,
    S_SEND     = 2'd2
  } send_state_t;

  localparam int DELAY          = 14;
  localparam int DMAC_FIRST_IDX = 0;
  localparam int DMAC_LAST_IDX  = 5;
  localparam int ETH_HI_IDX     = 12;
  localparam int ETH_LO_IDX     = 13;

  localparam int LEN_W    = 11;
  localparam int DMAC_W   = 48;
  localparam int CLASS_W  = 2;
  localparam int INPORT_W = 4;
  localparam logic [LEN_W-1:0] LEN_MAX = '1;

  // Descriptor layout, LSB first: dmac | bufid | len | class | inport
  localparam int DESC_DMAC_LSB  = 0;
  localparam int DESC_BUFID_LSB = DMAC_W;

  function automatic int desc_len_lsb(input int bufid_w);
    return DMAC_W + bufid_w;
  endfunction

  function automatic int desc_class_lsb(input int bufid_w);
    return DMAC_W + bufid_w + LEN_W;
  endfunction

  function automatic int desc_inport_lsb(input int bufid_w);
    return DMAC_W + bufid_w + LEN_W + CLASS_W;
  endfunction

  function automatic int desc_width(input int bufid_w);
    return DMAC_W + bufid_w + LEN_W + CLASS_W + INPORT_W;
  endfunction

  typedef struct packed {
    pkt_class_t        cls;
    logic [LEN_W-1:0]  len;
    logic [DMAC_W-1:0] dmac;
  } desc_entry_t;

  typedef struct packed {
    logic       valid;
    logic       sof;
    logic [8:0] data;
  } dly_word_t;

  function automatic pkt_class_t classify(input logic [15:0] eth,
                                          input logic [15:0] ts_eth,
                                          input logic [15:0] rc_eth);
    if (eth == ts_eth)      return CLS_TS;
    else if (eth == rc_eth) return CLS_RC;
    else                    return CLS_BE;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/desc_sync_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// desc_sync_fifo: synchronous FIFO whose full flag also counts reserved slots
// Revision: 1.0
// ----------------------------------------------------------------------------
module desc_sync_fifo #(
  parameter int WIDTH = 61,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             reserve,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    reserved;
  logic             do_pop;
  logic [CW:0]      occupied;

  assign do_pop   = pop && (count != '0);
  assign empty    = (count == '0);
  assign occupied = {1'b0, count} + {1'b0, reserved};
  assign full     = (occupied >= (CW+1)'(DEPTH));
  assign head     = mem[rd_ptr];

  // A push consumes the reservation made at admission, so reserved and count
  // together never exceed DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      reserved <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      unique case ({reserve, push})
        2'b10:   reserved <= reserved + CW'(1);
        2'b01:   reserved <= (reserved != '0) ? reserved - CW'(1) : reserved;
        default: reserved <= reserved;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/descriptor_extract_pq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// descriptor_extract_pq: frame parse, class admission, delay line, bufid pairing
// Revision: 1.0
// ----------------------------------------------------------------------------
module descriptor_extract_pq
  import descriptor_extract_pkg::*;
#(
  parameter logic [3:0]  INPORT     = 4'b0000,
  parameter int          DESC_DEPTH = 4,
  parameter int          BUFID_W    = 9,
  parameter logic [15:0] TS_ETHTYPE = 16'h1800,
  parameter logic [15:0] RC_ETHTYPE = 16'h1801
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [8:0]         iv_data,
  input  logic               i_data_wr,
  input  logic [BUFID_W-1:0] iv_free_bufid_num,
  input  logic [BUFID_W-1:0] iv_ts_threshold,
  input  logic [BUFID_W-1:0] iv_rc_threshold,
  input  logic [BUFID_W-1:0] iv_be_threshold,
  output logic [8:0]         ov_data,
  output logic               o_data_wr,
  input  logic               i_pkt_bufid_wr,
  input  logic [BUFID_W-1:0] iv_pkt_bufid,
  output logic               o_pkt_bufid_ack,
  output logic               o_descriptor_wr,
  output logic [64+BUFID_W:0] ov_descriptor,
  input  logic               i_descriptor_ack,
  output logic [15:0]        ov_drop_cnt_ts,
  output logic [15:0]        ov_drop_cnt_rc,
  output logic [15:0]        ov_drop_cnt_be,
  output logic [15:0]        ov_runt_cnt
);

  localparam int DESC_W = desc_width(BUFID_W);
  localparam int FIFO_W = $bits(desc_entry_t);
  localparam logic [LEN_W-1:0] IDX_DMAC_LAST = LEN_W'(DMAC_LAST_IDX);
  localparam logic [LEN_W-1:0] IDX_ETH_HI    = LEN_W'(ETH_HI_IDX);
  localparam logic [LEN_W-1:0] IDX_ETH_LO    = LEN_W'(ETH_LO_IDX);

  parse_state_t       pstate, pstate_nxt;
  send_state_t        sstate, sstate_nxt;
  logic               prev_wr;
  logic [LEN_W-1:0]   byte_cnt;
  logic [DMAC_W-1:0]  dmac;
  logic [7:0]         eth_hi;
  logic               admit_r;
  pkt_class_t         cls_r;
  logic               keep_r;
  logic [BUFID_W-1:0] bufid_r;
  dly_word_t          dly [DELAY];

  logic               first_byte, frame_byte, last_byte;
  logic [LEN_W-1:0]   cur_idx, len_now;
  pkt_class_t         cls_now, push_cls;
  logic [BUFID_W-1:0] thr;
  logic               decide, drop_now, kept_at_last;
  logic               reserve, push, runt, pop;
  logic               fifo_full, fifo_empty;
  desc_entry_t        push_entry, head;
  dly_word_t          dly_out;
  logic               keep_now;
  logic [DESC_W-1:0]  desc;

  // A first byte must follow an idle cycle, so the tail of a frame cut by
  // reset is never mistaken for a new frame start.
  always_comb begin
    first_byte = i_data_wr && iv_data[8] && !prev_wr;
    frame_byte = i_data_wr && (first_byte || (pstate == P_FRAME));
    last_byte  = frame_byte && iv_data[8] && !first_byte;
    cur_idx    = first_byte ? '0 : byte_cnt;
    len_now    = (cur_idx == LEN_MAX) ? LEN_MAX : cur_idx + LEN_W'(1);
    cls_now    = classify({eth_hi, iv_data[7:0]}, TS_ETHTYPE, RC_ETHTYPE);
    unique case (cls_now)
      CLS_TS:  thr = iv_ts_threshold;
      CLS_RC:  thr = iv_rc_threshold;
      default: thr = iv_be_threshold;
    endcase
    decide       = frame_byte && (cur_idx == IDX_ETH_LO);
    drop_now     = (iv_free_bufid_num <= thr) || fifo_full;
    reserve      = decide && !drop_now;
    kept_at_last = decide ? !drop_now : admit_r;
    push_cls     = decide ? cls_now : cls_r;
    push         = last_byte && kept_at_last && (cur_idx >= IDX_ETH_LO);
    runt         = last_byte && (cur_idx < IDX_ETH_LO);
    push_entry   = '{cls: push_cls, len: len_now, dmac: dmac};
  end

  always_comb begin
    pstate_nxt = pstate;
    if (first_byte)     pstate_nxt = P_FRAME;
    else if (last_byte) pstate_nxt = P_IDLE;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pstate         <= P_IDLE;
      prev_wr        <= 1'b0;
      byte_cnt       <= '0;
      dmac           <= '0;
      eth_hi         <= '0;
      admit_r        <= 1'b0;
      cls_r          <= CLS_TS;
      ov_drop_cnt_ts <= '0;
      ov_drop_cnt_rc <= '0;
      ov_drop_cnt_be <= '0;
      ov_runt_cnt    <= '0;
    end else begin
      pstate  <= pstate_nxt;
      prev_wr <= i_data_wr;
      if (first_byte) begin
        byte_cnt <= LEN_W'(1);
        admit_r  <= 1'b0;
      end else if (frame_byte && byte_cnt != LEN_MAX) begin
        byte_cnt <= byte_cnt + LEN_W'(1);
      end
      if (frame_byte && cur_idx <= IDX_DMAC_LAST) dmac <= {dmac[DMAC_W-9:0], iv_data[7:0]};
      if (frame_byte && cur_idx == IDX_ETH_HI) eth_hi <= iv_data[7:0];
      if (decide) begin
        admit_r <= !drop_now;
        cls_r   <= cls_now;
        if (drop_now) begin
          unique case (cls_now)
            CLS_TS:  ov_drop_cnt_ts <= sat_inc16(ov_drop_cnt_ts);
            CLS_RC:  ov_drop_cnt_rc <= sat_inc16(ov_drop_cnt_rc);
            default: ov_drop_cnt_be <= sat_inc16(ov_drop_cnt_be);
          endcase
        end
      end
      if (runt) ov_runt_cnt <= sat_inc16(ov_runt_cnt);
    end
  end

  // Admission is resolved one cycle before byte 0 reaches the end of the line.
  always_comb begin
    dly_out   = dly[DELAY-1];
    keep_now  = dly_out.sof ? admit_r : keep_r;
    o_data_wr = dly_out.valid && keep_now;
    ov_data   = o_data_wr ? dly_out.data : '0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DELAY; i++) dly[i] <= '0;
      keep_r <= 1'b0;
    end else begin
      dly[0] <= '{valid: frame_byte, sof: first_byte, data: iv_data};
      for (int i = 1; i < DELAY; i++) dly[i] <= dly[i-1];
      if (dly_out.valid) begin
        if (dly_out.sof)          keep_r <= admit_r;
        else if (dly_out.data[8]) keep_r <= 1'b0;
      end
    end
  end

  desc_sync_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (DESC_DEPTH)
  ) u_fifo (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .reserve   (reserve),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    sstate_nxt      = sstate;
    o_pkt_bufid_ack = 1'b0;
    o_descriptor_wr = 1'b0;
    pop             = 1'b0;
    unique case (sstate)
      S_IDLE: begin
        if (!fifo_empty) sstate_nxt = S_WAIT_BUF;
      end
      S_WAIT_BUF: begin
        if (i_pkt_bufid_wr) begin
          o_pkt_bufid_ack = 1'b1;
          sstate_nxt      = S_SEND;
        end
      end
      S_SEND: begin
        o_descriptor_wr = 1'b1;
        if (i_descriptor_ack) begin
          pop        = 1'b1;
          sstate_nxt = S_IDLE;
        end
      end
      default: sstate_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sstate  <= S_IDLE;
      bufid_r <= '0;
    end else begin
      sstate <= sstate_nxt;
      if (sstate == S_WAIT_BUF && i_pkt_bufid_wr) bufid_r <= iv_pkt_bufid;
    end
  end

  always_comb begin
    desc = '0;
    if (o_descriptor_wr) begin
      desc[DESC_DMAC_LSB +: DMAC_W]                 = head.dmac;
      desc[DESC_BUFID_LSB +: BUFID_W]               = bufid_r;
      desc[desc_len_lsb(BUFID_W) +: LEN_W]          = head.len;
      desc[desc_class_lsb(BUFID_W) +: CLASS_W]      = head.cls;
      desc[desc_inport_lsb(BUFID_W) +: INPORT_W]    = INPORT;
    end
    ov_descriptor = desc;
  end

endmodule
`default_nettype wire
